// File: rtl/contador_tempo_param.sv
// ---------------------------------------------------------------------------
// contador_tempo_param
//
// Parameterised timed up/down counter with a run/pause/done control FSM.
// A prescaler counts RUN cycles. Every CLK_DIV of them it produces one tick,
// and each tick steps the count. In wrap mode the count wraps around at its
// terminal value. In one-shot mode it stops there and enters DONE.
//
// Parameters
//   CLK_DIV  clock cycles per tick (>= 2)
//   MAX_VAL  highest count value (>= 1)
//   WIDTH    width of number / load_value (must hold MAX_VAL)
//   DIV_W    prescaler width (must hold CLK_DIV-1)
//
// Ports
//   clk            sole clock, all logic on posedge
//   reset_num      synchronous active-high reset (highest priority)
//   enable_switch  level: 1 = run, 0 = pause
//   up_down        1 = count up, 0 = count down
//   one_shot       0 = wrap mode, 1 = stop at terminal value
//   load           synchronous load strobe (beats any tick)
//   load_value     value captured on load, clamped to MAX_VAL
//   tick_segundo   one-cycle pulse per prescaler period
//   number         current count
//   wrap_pulse     one-cycle pulse on wrap-around
//   done           high while in DONE
//   state          IDLE=00, PAUSE=01, RUN=10, DONE=11
//
// Every output comes straight from a register.
// ---------------------------------------------------------------------------
module contador_tempo_param #(
  parameter int CLK_DIV = 50_000_000,
  parameter int MAX_VAL = 99,
  parameter int WIDTH   = 8,
  parameter int DIV_W   = 32
) (
  input  logic             clk,
  input  logic             reset_num,
  input  logic             enable_switch,
  input  logic             up_down,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tick_segundo,
  output logic [WIDTH-1:0] number,
  output logic             wrap_pulse,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PAUSE = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_VAL);
  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(CLK_DIV - 1);

  state_t           state_reg,  state_next;
  logic [DIV_W-1:0] presc_reg,  presc_next;
  logic [WIDTH-1:0] number_reg, number_next;
  logic             tick_reg,   tick_next;
  logic             wrap_reg,   wrap_next;
  logic             done_reg,   done_next;

  // The terminal value and the one-step neighbour follow the live direction
  // input. A direction change therefore takes effect at the very next tick
  // and leaves the prescaler alone.
  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] wrap_val;

  assign terminal = up_down ? MAX_W : '0;
  assign step_val = up_down ? (number_reg + WIDTH'(1)) : (number_reg - WIDTH'(1));
  assign wrap_val = up_down ? '0 : MAX_W;

  // State register. Reset overrides everything, including load and enable.
  always_ff @(posedge clk) begin
    if (reset_num) begin
      state_reg  <= IDLE;
      presc_reg  <= '0;
      number_reg <= '0;
      tick_reg   <= 1'b0;
      wrap_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      presc_reg  <= presc_next;
      number_reg <= number_next;
      tick_reg   <= tick_next;
      wrap_reg   <= wrap_next;
      done_reg   <= done_next;
    end
  end

  // Next-state logic. The pulses default to low, so a pulse lasts exactly
  // one cycle. Load is checked first, which means a tick that lands in the
  // same cycle as a load is dropped.
  always_comb begin
    state_next  = state_reg;
    presc_next  = presc_reg;
    number_next = number_reg;
    tick_next   = 1'b0;
    wrap_next   = 1'b0;
    done_next   = done_reg;

    if (load) begin
      number_next = (load_value > MAX_W) ? MAX_W : load_value;
      presc_next  = '0;
      done_next   = 1'b0;
      state_next  = IDLE;
    end else begin
      case (state_reg)
        IDLE, PAUSE: begin
          // The prescaler is not touched here. After a pause, the period in
          // progress only finishes its remaining cycles.
          if (enable_switch) state_next = RUN;
        end

        RUN: begin
          if (!enable_switch) begin
            state_next = PAUSE;
          end else if (presc_reg == PRESC_LAST) begin
            presc_next = '0;
            tick_next  = 1'b1;
            if (one_shot) begin
              // Already at the terminal value: stop without stepping.
              // Otherwise take the step, and stop if it lands on the terminal.
              if (number_reg == terminal) begin
                state_next = DONE;
                done_next  = 1'b1;
              end else begin
                number_next = step_val;
                if (step_val == terminal) begin
                  state_next = DONE;
                  done_next  = 1'b1;
                end
              end
            end else if (number_reg == terminal) begin
              number_next = wrap_val;
              wrap_next   = 1'b1;
            end else begin
              number_next = step_val;
            end
          end else begin
            presc_next = presc_reg + DIV_W'(1);
          end
        end

        DONE: begin
          // Frozen until a load or a reset arrives.
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign tick_segundo = tick_reg;
  assign number       = number_reg;
  assign wrap_pulse   = wrap_reg;
  assign done         = done_reg;
  assign state        = state_reg;

endmodule

// File: tb/tb_contador_tempo_param.sv
// ---------------------------------------------------------------------------
// tb_contador_tempo_param
//
// Bench for contador_tempo_param with CLK_DIV=4, MAX_VAL=9, WIDTH=8.
// A behavioural model runs in lockstep with the design. It counts RUN cycles
// and applies the counting rules with modular arithmetic. Each clock cycle
// the bench compares every output against the model. Directed scenarios
// also check fixed expected values, and a randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_contador_tempo_param;

  localparam int CLK_DIV = 4;
  localparam int MAX_VAL = 9;
  localparam int WIDTH   = 8;
  localparam int DIV_W   = 8;

  logic             clk = 1'b0;
  logic             reset_num;
  logic             enable_switch;
  logic             up_down;
  logic             one_shot;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             tick_segundo;
  logic [WIDTH-1:0] number;
  logic             wrap_pulse;
  logic             done;
  logic [1:0]       state;

  always #5 clk = ~clk;

  contador_tempo_param #(
    .CLK_DIV(CLK_DIV),
    .MAX_VAL(MAX_VAL),
    .WIDTH  (WIDTH),
    .DIV_W  (DIV_W)
  ) dut (
    .clk          (clk),
    .reset_num    (reset_num),
    .enable_switch(enable_switch),
    .up_down      (up_down),
    .one_shot     (one_shot),
    .load         (load),
    .load_value   (load_value),
    .tick_segundo (tick_segundo),
    .number       (number),
    .wrap_pulse   (wrap_pulse),
    .done         (done),
    .state        (state)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model. m_mode: 0 idle, 1 paused, 2 running, 3 finished.
  int m_num, m_presc, m_tick, m_wrap, m_done, m_mode;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int term;
    int dir;
    if (reset_num) begin
      m_num = 0; m_presc = 0; m_tick = 0; m_wrap = 0; m_done = 0; m_mode = 0;
    end else if (load) begin
      m_num = (int'(load_value) > MAX_VAL) ? MAX_VAL : int'(load_value);
      m_presc = 0; m_tick = 0; m_wrap = 0; m_done = 0; m_mode = 0;
    end else begin
      m_tick = 0;
      m_wrap = 0;
      case (m_mode)
        0, 1: if (enable_switch) m_mode = 2;
        2: begin
          if (!enable_switch) begin
            m_mode = 1;
          end else if (m_presc == CLK_DIV - 1) begin
            m_presc = 0;
            m_tick  = 1;
            term = up_down ? MAX_VAL : 0;
            dir  = up_down ? 1 : -1;
            if (one_shot) begin
              if (m_num != term) m_num = m_num + dir;
              if (m_num == term) begin
                m_mode = 3;
                m_done = 1;
              end
            end else begin
              m_num  = (m_num + dir + MAX_VAL + 1) % (MAX_VAL + 1);
              m_wrap = (m_num == (up_down ? 0 : MAX_VAL)) ? 1 : 0;
            end
          end else begin
            m_presc++;
          end
        end
        default: ;
      endcase
    end
  endtask

  // Advance one clock. The model sees the same inputs as the design. The
  // outputs are sampled 1 ns after the edge and compared with the model.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".number"}, 32'(number),       32'(m_num));
    check({tag, ".tick"},   32'(tick_segundo), 32'(m_tick));
    check({tag, ".wrap"},   32'(wrap_pulse),   32'(m_wrap));
    check({tag, ".done"},   32'(done),         32'(m_done));
    check({tag, ".state"},  32'(state),        32'(m_mode));
  endtask

  // Step until a tick appears, but give up after a fixed number of cycles.
  task automatic wait_tick(input string tag, input int limit, output int n);
    n = 0;
    do begin
      step(tag);
      n++;
    end while (!tick_segundo && n < limit);
    check({tag, ".tick_seen"}, 32'(tick_segundo), 32'd1);
  endtask

  initial begin
    int n;
    int held;
    reset_num = 1'b1; enable_switch = 1'b0; up_down = 1'b1;
    one_shot  = 1'b0; load = 1'b0; load_value = '0;

    // Reset state.
    step("reset");
    step("reset");
    check("reset.number_zero", 32'(number), 32'd0);
    check("reset.state_idle",  32'(state),  32'd0);

    // Up-count wrap: 1..9, then 0 with wrap_pulse on the 9->0 tick only.
    reset_num = 1'b0; enable_switch = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      wait_tick("up", 12, n);
      check("up.value", 32'(number),     32'(k % 10));
      check("up.wrap",  32'(wrap_pulse), (k == 10) ? 32'd1 : 32'd0);
      if (k > 1) check("up.period", 32'(n), 32'd4);
    end

    // Down-count wrap: load 0, first tick gives 9 with wrap, then 8, 7.
    load = 1'b1; load_value = 8'd0; up_down = 1'b0;
    step("dn_load");
    load = 1'b0;
    wait_tick("dn", 12, n);
    check("dn.first",      32'(number),     32'd9);
    check("dn.first_wrap", 32'(wrap_pulse), 32'd1);
    wait_tick("dn", 12, n);
    check("dn.second", 32'(number), 32'd8);
    check("dn.no_wrap", 32'(wrap_pulse), 32'd0);
    wait_tick("dn", 12, n);
    check("dn.third", 32'(number), 32'd7);

    // One-shot up: load 7 -> 8 -> 9 and DONE, held, then reload 3.
    load = 1'b1; load_value = 8'd7; up_down = 1'b1; one_shot = 1'b1;
    step("os_load");
    load = 1'b0;
    wait_tick("os", 12, n);
    check("os.eight", 32'(number), 32'd8);
    check("os.not_done", 32'(done), 32'd0);
    wait_tick("os", 12, n);
    check("os.nine",  32'(number), 32'd9);
    check("os.done",  32'(done),   32'd1);
    check("os.state", 32'(state),  32'd3);
    for (int i = 0; i < 20; i++) begin
      step("os_hold");
      check("os_hold.number", 32'(number),       32'd9);
      check("os_hold.tick",   32'(tick_segundo), 32'd0);
    end
    load = 1'b1; load_value = 8'd3;
    step("os_reload");
    load = 1'b0;
    check("os_reload.done",   32'(done),   32'd0);
    check("os_reload.state",  32'(state),  32'd0);
    check("os_reload.number", 32'(number), 32'd3);

    // Pause/resume: drop enable 2 cycles into a period, then resume.
    one_shot = 1'b0;
    wait_tick("pr", 12, n);
    step("pr_run");
    step("pr_run");
    enable_switch = 1'b0;
    held = int'(number);
    for (int i = 0; i < 10; i++) begin
      step("pr_pause");
      check("pr_pause.state",  32'(state),  32'd1);
      check("pr_pause.number", 32'(number), 32'(held));
    end
    enable_switch = 1'b1;
    step("pr_resume");
    check("pr_resume.state", 32'(state), 32'd2);
    wait_tick("pr_rest", 8, n);
    check("pr_resume.remaining", 32'(n), 32'd2);

    // Load clamp, then a load that lands on a tick cycle.
    load = 1'b1; load_value = 8'd15;
    step("clamp");
    load = 1'b0;
    check("clamp.number", 32'(number), 32'd9);
    n = 0;
    while (!(m_mode == 2 && m_presc == CLK_DIV - 1) && n < 12) begin
      step("col_run");
      n++;
    end
    check("col.reached", (m_mode == 2 && m_presc == CLK_DIV - 1) ? 32'd1 : 32'd0, 32'd1);
    load = 1'b1; load_value = 8'd5;
    step("col");
    load = 1'b0;
    check("col.number", 32'(number),       32'd5);
    check("col.tick",   32'(tick_segundo), 32'd0);

    // Reset beats load mid-RUN.
    for (int i = 0; i < 6; i++) step("rp_run");
    reset_num = 1'b1; load = 1'b1; load_value = 8'd7;
    step("rp");
    reset_num = 1'b0; load = 1'b0;
    check("rp.number", 32'(number),       32'd0);
    check("rp.state",  32'(state),        32'd0);
    check("rp.tick",   32'(tick_segundo), 32'd0);
    check("rp.wrap",   32'(wrap_pulse),   32'd0);
    check("rp.done",   32'(done),         32'd0);

    // Randomized phase against the model.
    for (int i = 0; i < 2000; i++) begin
      reset_num     = ($urandom_range(0, 63) == 0);
      load          = ($urandom_range(0, 31) == 0);
      load_value    = 8'($urandom_range(0, 15));
      enable_switch = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 15) == 0) up_down  = ~up_down;
      if ($urandom_range(0, 31) == 0) one_shot = ~one_shot;
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/contador_tempo_param.md
CONTADOR_TEMPO_PARAM -- requirements
Module: contador_tempo_param

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50_000_000, meaning clock cycles per tick (>=2).
REQ-002 SHALL have parameter MAX_VAL, default 99, meaning the highest count value (>=1).
REQ-003 SHALL have parameter WIDTH, default 8, meaning the bit width of number and load_value (must hold MAX_VAL).
REQ-004 SHALL have parameter DIV_W, default 32, meaning the prescaler width (must hold CLK_DIV-1).
REQ-005 clk  input  1  sole clock; all logic on posedge.
REQ-006 reset_num  input  1  synchronous, active-high reset.
REQ-007 enable_switch  input  1  level; 1=run, 0=pause.
REQ-008 up_down  input  1  1=count up, 0=count down.
REQ-009 one_shot  input  1  0=wrap mode, 1=stop at terminal value.
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_value  input  WIDTH  value captured on load.
REQ-012 tick_segundo  output  1  one-cycle pulse per prescaler period.
REQ-013 number  output  WIDTH  current count.
REQ-014 wrap_pulse  output  1  one-cycle pulse on wrap-around.
REQ-015 done  output  1  level; high while in DONE.
REQ-016 state  output  2  IDLE=00, PAUSE=01, RUN=10, DONE=11.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 Priority SHALL be: reset_num, then load, then tick processing.
REQ-019 Transitions SHALL be: IDLE->RUN and PAUSE->RUN when enable_switch=1; RUN->PAUSE when enable_switch=0; RUN->DONE on a terminal tick in one_shot mode; any state->IDLE on load.
REQ-020 The prescaler SHALL increment only in RUN; at CLK_DIV-1 it SHALL return to 0 and tick_segundo SHALL be 1 for exactly that next cycle, in the same cycle number updates.
REQ-021 In PAUSE the prescaler SHALL hold its value (not clear), so a resumed period completes the remaining cycles only.
REQ-022 The terminal value SHALL be MAX_VAL when up_down=1 and 0 when up_down=0.
REQ-023 A tick in wrap mode when up and number=MAX_VAL SHALL set number to 0 and pulse wrap_pulse; a tick when down and number=0 SHALL set number to MAX_VAL and pulse wrap_pulse; any other tick SHALL step number by +/-1.
REQ-024 A tick in one_shot mode whose step yields the terminal value SHALL update number, enter DONE, and clear the prescaler.
REQ-025 A tick in one_shot mode when number already equals the terminal value SHALL enter DONE with number unchanged.
REQ-026 wrap_pulse SHALL never assert in one_shot mode.
REQ-027 DONE SHALL hold number, with tick_segundo=0 and wrap_pulse=0, regardless of enable_switch, until load or reset.
REQ-028 Load SHALL set number to min(load_value, MAX_VAL), clear the prescaler, deassert done, enter IDLE, and force tick_segundo=0 and wrap_pulse=0 that cycle.
REQ-029 A load coincident with a tick SHALL win; that tick is discarded.
REQ-030 up_down and one_shot changes SHALL take effect at the next tick and SHALL NOT clear the prescaler.

Reset
REQ-031 Reset SHALL set number=0, prescaler=0, tick_segundo=0, wrap_pulse=0, done=0, state=IDLE on the next posedge, overriding load and enable_switch, from any state including mid-period.

Verification (CLK_DIV=4, MAX_VAL=9, WIDTH=8)
REQ-032 Bench SHALL check up-count wrap: reset, enable=1, up=1, one_shot=0 -> tick every 4 cycles; number 1..9 then 0 with wrap_pulse coincident with the 9->0 tick only.
REQ-033 Bench SHALL check down-count wrap: load 0, up=0, enable=1 -> first tick gives number=9 with wrap_pulse=1, then 8, 7, ...
REQ-034 Bench SHALL check one-shot up: load 7, one_shot=1, up=1, enable=1 -> number 8, then 9 with done=1 and state=11; 20 further cycles show number=9, tick_segundo=0; load 3 -> done=0, state=00, number=3.
REQ-035 Bench SHALL check pause resume: enable drops 2 cycles into a period and is held low 10 cycles with state=01 and number constant -> after re-enable the next tick occurs after 2 cycles, not 4.
REQ-036 Bench SHALL check load clamp and collision: load_value=15 -> number=9; load asserted on a tick cycle -> number=load value and tick_segundo=0.
REQ-037 Bench SHALL check reset priority: reset_num and load both high mid-RUN -> number=0, state=00, all pulses and done low.
